// File: rtl/malu_result_fifo_if.sv
// malu_result_fifo_if
//   Bundles the malu_result_fifo handshake, data and status signals.
//   Modports:
//     slave  - the FIFO's view: it takes in_valid/in_data/out_ready/ovf_clr
//              and drives in_ready, out_valid, out_data and the status outputs.
//     master - the surrounding logic's view: producer, consumer and status reader.
//   Signals:
//     in_valid/in_data/in_ready     upstream malu result handshake
//     out_valid/out_data/out_ready  downstream consumer handshake
//     count/full/empty              occupancy status
//     checksum                      XOR of every accepted result
//     ovf/ovf_clr                   sticky overflow flag and its clear
interface malu_result_fifo_if #(
  parameter int WIDTH      = 4,
  parameter int DEPTH_LOG2 = 2
);
  logic                  in_valid;
  logic [WIDTH-1:0]      in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  empty;
  logic [WIDTH-1:0]      checksum;
  logic                  ovf;
  logic                  ovf_clr;

  modport slave (
    input  in_valid, in_data, out_ready, ovf_clr,
    output in_ready, out_valid, out_data, count, full, empty, checksum, ovf
  );

  modport master (
    output in_valid, in_data, out_ready, ovf_clr,
    input  in_ready, out_valid, out_data, count, full, empty, checksum, ovf
  );
endinterface

// File: rtl/malu_result_fifo.sv
// malu_result_fifo
//   Registered result buffer downstream of the malu combinational stage.
//   Captures each valid malu result into a small circular FIFO and drains it
//   to a consumer over valid/ready with first-word fall-through. Also keeps
//   an occupancy count, a running XOR checksum of accepted results and a
//   sticky overflow flag for results presented while full.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - malu_result_fifo_if.slave (handshakes, data, status, ovf_clr)
module malu_result_fifo #(
  parameter int WIDTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  malu_result_fifo_if.slave     bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic [WIDTH-1:0]      checksum_q;
  logic                  ovf_q;

  logic full_w;
  logic empty_w;
  logic push;
  logic pop;

  // Ready depends only on registered occupancy, so there is no combinational
  // path from out_ready to in_ready; a full FIFO refuses even while popping.
  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);
  assign push    = bus.in_valid && !full_w;
  assign pop     = !empty_w && bus.out_ready;

  // NOTE: the storage array has no reset; entries are only observable once
  // written, and leaving it unreset lets it map to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      checksum_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      // Pointers wrap modulo DEPTH by natural overflow.
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        checksum_q <= checksum_q ^ bus.in_data;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase

      // A refused result sets the flag even if a clear arrives the same cycle.
      if (bus.in_valid && full_w) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !full_w;
  assign bus.out_valid = !empty_w;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.checksum  = checksum_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_malu_result_fifo.sv
// tb_malu_result_fifo
//   Directed testbench for malu_result_fifo: reset, fill/drain ordering,
//   overflow set/clear priority, full-with-pop, steady push+pop with pointer
//   wrap, empty-edge latency and mid-operation reset.
module tb_malu_result_fifo;

  localparam int WIDTH      = 4;
  localparam int DEPTH_LOG2 = 2;

  logic clk = 1'b0;
  logic rst;

  malu_result_fifo_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  malu_result_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  // and new inputs are applied there, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  logic [3:0] steady_in [6];
  logic [3:0] model_q [$];

  initial begin
    steady_in[0] = 4'hA; steady_in[1] = 4'hB; steady_in[2] = 4'hC;
    steady_in[3] = 4'hD; steady_in[4] = 4'hE; steady_in[5] = 4'h1;

    // Reset with a valid result presented: it must be ignored.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hF;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    tick();
    tick();
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_empty",    32'(bus.empty),    32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_checksum", 32'(bus.checksum), 32'd0);
    check("rst_ovf",      32'(bus.ovf),      32'd0);
    check("rst_outvalid", 32'(bus.out_valid), 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    // Ordered fill with consumer stalled.
    push_one(4'h1);
    check("fill1_count", 32'(bus.count), 32'd1);
    check("fill1_head",  32'(bus.out_data), 32'h1);
    push_one(4'h2);
    push_one(4'h2);
    push_one(4'h6);
    check("fill_full",     32'(bus.full),     32'd1);
    check("fill_count",    32'(bus.count),    32'd4);
    check("fill_checksum", 32'(bus.checksum), 32'h7);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);

    // Drain in order.
    bus.out_ready = 1'b1;
    check("drain0", 32'(bus.out_data), 32'h1);
    tick();
    check("drain1", 32'(bus.out_data), 32'h2);
    tick();
    check("drain2", 32'(bus.out_data), 32'h2);
    tick();
    check("drain3", 32'(bus.out_data), 32'h6);
    check("drain3_valid", 32'(bus.out_valid), 32'd1);
    tick();
    check("drain_empty",    32'(bus.empty),    32'd1);
    check("drain_count",    32'(bus.count),    32'd0);
    check("drain_checksum", 32'(bus.checksum), 32'h7);
    bus.out_ready = 1'b0;

    // Refill with data whose XOR is zero so the checksum stays 7.
    push_one(4'h8);
    push_one(4'h4);
    push_one(4'h4);
    push_one(4'h8);
    check("refill_count",    32'(bus.count),    32'd4);
    check("refill_checksum", 32'(bus.checksum), 32'h7);

    // Overflow while full.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    check("ovf_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("ovf_set",      32'(bus.ovf),      32'd1);
    check("ovf_checksum", 32'(bus.checksum), 32'h7);
    check("ovf_count",    32'(bus.count),    32'd4);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.ovf), 32'd0);

    // Set wins over clear in the same cycle.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    bus.ovf_clr  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.ovf_clr  = 1'b0;
    check("ovf_set_wins", 32'(bus.ovf), 32'd1);

    // Full with pop and in_valid: pop happens, push refused, ovf stays set.
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr2", 32'(bus.ovf), 32'd0);
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h3;
    bus.out_ready = 1'b1;
    check("fullpop_head", 32'(bus.out_data), 32'h8);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("fullpop_count",    32'(bus.count),    32'd3);
    check("fullpop_ovf",      32'(bus.ovf),      32'd1);
    check("fullpop_checksum", 32'(bus.checksum), 32'h7);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;

    // Pop one more to reach count = 2 (queue 4, 8).
    bus.out_ready = 1'b1;
    tick();
    check("steady_start_count", 32'(bus.count), 32'd2);
    model_q = '{4'h4, 4'h8};

    // Six cycles of simultaneous push and pop; read pointer crosses 3 -> 0.
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = steady_in[i];
      check($sformatf("steady_head%0d", i), 32'(bus.out_data), 32'(model_q[0]));
      tick();
      void'(model_q.pop_front());
      model_q.push_back(steady_in[i]);
      check($sformatf("steady_count%0d", i), 32'(bus.count), 32'd2);
    end
    bus.in_valid = 1'b0;
    // 7 ^ A ^ B ^ C ^ D ^ E ^ 1 = 8
    check("steady_checksum", 32'(bus.checksum), 32'h8);
    check("steady_tail0", 32'(bus.out_data), 32'hE);
    tick();
    check("steady_tail1", 32'(bus.out_data), 32'h1);
    tick();
    check("steady_empty", 32'(bus.empty), 32'd1);

    // Empty edge: no bypass, one-cycle latency, then gone with out_ready held.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h6;
    check("edge_push_cycle_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("edge_valid", 32'(bus.out_valid), 32'd1);
    check("edge_data",  32'(bus.out_data),  32'h6);
    tick();
    check("edge_gone",  32'(bus.out_valid), 32'd0);
    check("edge_empty", 32'(bus.empty),     32'd1);
    bus.out_ready = 1'b0;

    // Reset mid-operation with count = 3; push in the reset cycle is ignored.
    push_one(4'h2);
    push_one(4'h3);
    push_one(4'h4);
    check("mid_count3", 32'(bus.count), 32'd3);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h5;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("mid_rst_count",    32'(bus.count),    32'd0);
    check("mid_rst_checksum", 32'(bus.checksum), 32'd0);
    check("mid_rst_empty",    32'(bus.empty),    32'd1);
    push_one(4'h1);
    check("mid_post_valid",    32'(bus.out_valid), 32'd1);
    check("mid_post_data",     32'(bus.out_data),  32'h1);
    check("mid_post_checksum", 32'(bus.checksum),  32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
